// File: rtl/regfile_bypass.sv
// Register file with registered read ports, same-cycle write-to-read bypass,
// hard-wired zero register, pending scoreboard and register-0 write error tracking.
module regfile_bypass #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned SP_IDX = 29,
  parameter int unsigned SP_RST = 252,
  parameter int unsigned ERRC_W = 8
) (
  input  logic                       elk,
  input  logic                       nrst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  input  logic                       rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic                       rd_valid,
  output logic                       err_r0,
  output logic [ERRC_W-1:0]          err_cnt
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        regs [DEPTH];
  logic [DEPTH-1:0]         pending;
  logic                     wr_ok;
  logic                     wr_r0;
  logic [NUM_RD*DATA_W-1:0] rd_data_nxt;
  logic [NUM_RD-1:0]        rd_busy_nxt;
  logic [ADDR_W-1:0]        ra;
  logic                     hit;

  assign wr_ok = wr_en && (wr_addr != '0);
  assign wr_r0 = wr_en && (wr_addr == '0);

  // Register array; entry 0 is never written so it stays zero
  always_ff @(posedge elk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[ADDR_W'(i)] <= (i == SP_IDX) ? DATA_W'(SP_RST) : '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard: a same-cycle reserve overrides the clearing write (newer producer)
  always_ff @(posedge elk or negedge nrst) begin
    if (!nrst) begin
      pending <= '0;
    end else begin
      if (wr_ok) begin
        pending[wr_addr] <= 1'b0;
      end
      if (rsv_en && (rsv_addr != '0)) begin
        pending[rsv_addr] <= 1'b1;
      end
    end
  end

  // Per-port read selection with bypass from the write port
  always_comb begin
    rd_data_nxt = '0;
    rd_busy_nxt = '0;
    ra          = '0;
    hit         = 1'b0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra  = rd_addr[i*ADDR_W +: ADDR_W];
      hit = wr_en && (wr_addr == ra);
      if (ra == '0) begin
        rd_data_nxt[i*DATA_W +: DATA_W] = '0;
      end else if (hit) begin
        rd_data_nxt[i*DATA_W +: DATA_W] = wr_data;
      end else begin
        rd_data_nxt[i*DATA_W +: DATA_W] = regs[ra];
      end
      rd_busy_nxt[i] = pending[ra] && !(hit && (ra != '0));
    end
  end

  always_ff @(posedge elk or negedge nrst) begin
    if (!nrst) begin
      rd_data  <= '0;
      rd_busy  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_data <= rd_data_nxt;
        rd_busy <= rd_busy_nxt;
      end
      rd_valid <= rd_en;
    end
  end

  // Sticky error and saturating counter for register-0 writes
  always_ff @(posedge elk or negedge nrst) begin
    if (!nrst) begin
      err_r0  <= 1'b0;
      err_cnt <= '0;
    end else if (wr_r0) begin
      err_r0 <= 1'b1;
      if (err_cnt != '1) begin
        err_cnt <= err_cnt + ERRC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_bypass.sv
// Scoreboard bench for regfile_bypass: a reference model predicts each cycle's
// outputs, pushes them to a queue, and they are popped and compared after the edge.
module tb_regfile_bypass;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned ERRC_W = 8;

  logic                     elk;
  logic                     nrst;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     rd_valid;
  logic                     err_r0;
  logic [ERRC_W-1:0]        err_cnt;

  regfile_bypass #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
    .SP_IDX(29), .SP_RST(252), .ERRC_W(ERRC_W)
  ) dut (
    .elk(elk), .nrst(nrst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .rd_valid(rd_valid),
    .err_r0(err_r0), .err_cnt(err_cnt)
  );

  initial elk = 1'b0;
  always #5 elk = ~elk;

  typedef struct {
    string       tag;
    logic [63:0] data;
    logic [1:0]  busy;
    logic        valid;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp;
  int          n_bad;

  logic [31:0] m_reg [32];
  logic [31:0] m_pend;
  logic [31:0] m_rd [2];
  logic [1:0]  m_busy;
  logic        m_valid;
  logic        m_err;
  logic [7:0]  m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_reg[29] = 32'h0000_00FC;
    m_pend  = 32'h0;
    m_rd[0] = 32'h0;
    m_rd[1] = 32'h0;
    m_busy  = 2'b00;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 8'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".data"},  64'(rd_data),  64'h0);
    check({tag, ".busy"},  64'(rd_busy),  64'h0);
    check({tag, ".valid"}, 64'(rd_valid), 64'h0);
    check({tag, ".err"},   64'(err_r0),   64'h0);
    check({tag, ".cnt"},   64'(err_cnt),  64'h0);
  endtask

  // One clock cycle: drive, predict, push; then pop and compare after the edge
  task automatic step(input string tag,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic re, input logic [4:0] a0, input logic [4:0] a1,
                      input logic rv, input logic [4:0] ra);
    logic [4:0] a;
    logic       hit;
    exp_t       e;
    exp_t       g;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rd_en    = re;
    rd_addr  = {a1, a0};
    rsv_en   = rv;
    rsv_addr = ra;
    if (re) begin
      for (int p = 0; p < 2; p++) begin
        a   = (p == 0) ? a0 : a1;
        hit = we && (wa == a);
        if (a == 5'd0)  m_rd[p] = 32'h0;
        else if (hit)   m_rd[p] = wd;
        else            m_rd[p] = m_reg[a];
        m_busy[p] = m_pend[a] && !(hit && a != 5'd0);
      end
    end
    m_valid = re;
    if (we && wa != 5'd0) begin
      m_reg[wa]  = wd;
      m_pend[wa] = 1'b0;
    end
    if (we && wa == 5'd0) begin
      m_err = 1'b1;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    if (rv && ra != 5'd0) m_pend[ra] = 1'b1;
    e.tag   = tag;
    e.data  = {m_rd[1], m_rd[0]};
    e.busy  = m_busy;
    e.valid = m_valid;
    e.err   = m_err;
    e.cnt   = m_cnt;
    sb_q.push_back(e);
    @(posedge elk);
    #1;
    g = sb_q.pop_front();
    check({g.tag, ".data"},  64'(rd_data),  g.data);
    check({g.tag, ".busy"},  64'(rd_busy),  64'(g.busy));
    check({g.tag, ".valid"}, 64'(rd_valid), 64'(g.valid));
    check({g.tag, ".err"},   64'(err_r0),   64'(g.err));
    check({g.tag, ".cnt"},   64'(err_cnt),  64'(g.cnt));
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nrst = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
    rd_en = 1'b0; rd_addr = '0;
    model_reset();
    #3;
    check_reset_outputs("por");
    @(posedge elk);
    #1;
    nrst = 1'b1;

    // Reset values: SP register and an ordinary register
    step("rst_rd",  1'b0, 5'd0, 32'h0, 1'b1, 5'd29, 5'd5, 1'b0, 5'd0);
    check("sp_val", 64'(rd_data[31:0]), 64'h0000_00FC);

    // Write then read on both ports
    step("wr7",     1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    step("rd7",     1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 1'b0, 5'd0);
    check("rd7_lit", 64'(rd_data), 64'hDEAD_BEEF_DEAD_BEEF);

    // Bypass on port 0, old value on port 1
    step("wr4",     1'b1, 5'd4, 32'hA5A5_0004, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    step("byp",     1'b1, 5'd3, 32'h1234_5678, 1'b1, 5'd3, 5'd4, 1'b0, 5'd0);
    check("byp_lit", 64'(rd_data), 64'hA5A5_0004_1234_5678);

    // Register 0 writes: ignored data, sticky error, saturating count
    for (int i = 0; i < 3; i++)
      step("wr0",   1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    step("rd0",     1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
    check("cnt3", 64'(err_cnt), 64'd3);
    step("rd0byp",  1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
    for (int i = 0; i < 300; i++)
      step("wr0sat", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    check("cnt_sat", 64'(err_cnt), 64'hFF);

    // Scoreboard
    step("rsv10",   1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd10, 1'b1, 5'd10);
    check("rsv_invis", 64'(rd_busy), 64'h0);
    step("rd10",    1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd2, 1'b0, 5'd0);
    check("busy10", 64'(rd_busy), 64'h1);
    step("wrrd10",  1'b1, 5'd10, 32'hCAFE_000A, 1'b1, 5'd10, 5'd10, 1'b0, 5'd0);
    check("clr10", 64'(rd_busy), 64'h0);
    step("rsvwr11", 1'b1, 5'd11, 32'h0000_0B0B, 1'b0, 5'd0, 5'd0, 1'b1, 5'd11);
    step("rd11",    1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd11, 1'b0, 5'd0);
    check("busy11", 64'(rd_busy), 64'h2);
    step("rsv0",    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0);
    step("rd0b",    1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd11, 1'b0, 5'd0);

    // Hold with rd_en low: valid 1,0,0 and data unchanged
    step("hold_rd", 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd7, 1'b0, 5'd0);
    idle("hold1");
    step("hold2",   1'b1, 5'd3, 32'h5555_AAAA, 1'b0, 5'd3, 5'd7, 1'b1, 5'd7);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step("rnd", 1'($urandom), 5'($urandom), $urandom, 1'($urandom_range(0, 3) != 0),
           5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom));

    // Mid-operation asynchronous reset discards writes and reservations
    step("pre_rst", 1'b1, 5'd12, 32'h0C0C_0C0C, 1'b1, 5'd12, 5'd29, 1'b1, 5'd12);
    step("pre_rst2",1'b1, 5'd0, 32'h1, 1'b1, 5'd12, 5'd29, 1'b1, 5'd29);
    #2;
    nrst = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("mid_rst");
    @(posedge elk);
    #1;
    check_reset_outputs("mid_rst_hold");
    nrst = 1'b1;
    step("post_rst", 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd29, 1'b0, 5'd0);
    check("post_rst_lit", 64'(rd_data), 64'h0000_00FC_0000_0000);

    if (sb_q.size() != 0) check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_bypass.md
# regfile_bypass

Parametrised general-purpose register file for the processor datapath, between decode (read operands) and writeback (write result). Supports NUM_RD registered read ports, one write port with same-cycle write-to-read bypass, a hard-wired zero register, and a per-register pending scoreboard. The scoreboard lets decode detect RAW hazards against in-flight producers. It also provides a sticky error flag and a saturating counter for illegal writes to register 0.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- SP_IDX, 29, index of the stack-pointer register given a non-zero reset value
- SP_RST, 252, reset value of register SP_IDX (truncated to DATA_W)
- ERRC_W, 8, width of the illegal-write counter
- elk  in  1  clock; all state updates on rising edge
- nrst  in  1  reset, asynchronous assert, active-low; synchronous release is handled upstream
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  mark register rsv_addr pending (producer issued)
- rsv_addr  in  ADDR_W  register to reserve
- rd_en  in  1  read strobe, common to all ports
- rd_addr  in  NUM_RD*ADDR_W  port i address in bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  port i data in bits [i*DATA_W +: DATA_W], registered
- rd_busy  out  NUM_RD  port i operand still pending, registered alongside rd_data
- rd_valid  out  1  rd_data/rd_busy updated by a read in the previous cycle
- err_r0  out  1  sticky; set by any write attempt to register 0
- err_cnt  out  ERRC_W  count of register-0 write attempts, saturating at all-ones

## Operation
- Reset (nrst low): all registers 0 except reg[SP_IDX] = SP_RST. pending[] all 0. rd_data 0, rd_busy 0, rd_valid 0, err_r0 0, err_cnt 0. Reset mid-operation discards all in-flight state immediately.
- Register 0: always reads 0. It is never pending. Reserve to 0 is ignored.
- Write: when wr_en and wr_addr != 0, reg[wr_addr] <= wr_data and pending[wr_addr] <= 0.
- Write with wr_addr == 0: the register is unchanged; err_r0 <= 1; err_cnt increments unless it is all-ones.
- Reserve: when rsv_en and rsv_addr != 0, pending[rsv_addr] <= 1.
- Reserve and write to the same address in the same cycle: the reserve wins (a newer producer), so pending ends at 1. The data write still happens.
- Read (rd_en=1), per port i with address a:
  - rd_data[i] <= 0 if a == 0.
  - Otherwise rd_data[i] <= wr_data if (wr_en && wr_addr == a); this is the bypass.
  - Otherwise rd_data[i] <= reg[a].
  - rd_busy[i] <= pending[a] && !(wr_en && wr_addr == a && a != 0). A same-cycle reserve of a is not visible to this read.
- rd_en = 0: rd_data and rd_busy hold their values; rd_valid <= 0.
- rd_valid <= rd_en every cycle.
- Ports are independent. Several ports may read the same address, and all receive identical values.

## Timing
- Read latency: 1 cycle. Address and rd_en are sampled at edge N; rd_data, rd_busy and rd_valid are valid after edge N until edge N+1.
- Write-to-read: a write at edge N is visible to a read sampled at the same edge N through the bypass. No stall cycle is ever needed.
- Reserve is visible to reads sampled at edge N+1 onward.
- err_r0 and err_cnt update at the edge that samples the illegal write.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: pulse nrst low asynchronously mid-cycle. Required immediately: all outputs 0. After release, read ports 0/1 with addrs 29/5 → rd_data 0x000000FC / 0x00000000, rd_valid=1 one cycle later.
- Write then read: write 0xDEADBEEF to r7. On the next cycle read r7 on both ports → both 0xDEADBEEF, rd_busy=0.
- Bypass: in the same cycle, write 0x12345678 to r3 and read r3 (port 0) and r4 (port 1) → port 0 = 0x12345678, port 1 = old r4.
- Register 0: write 0xFFFFFFFF to r0 three times, then read r0 → rd_data 0, err_r0=1, err_cnt=3. Drive 300 further r0 writes → err_cnt stays 0xFF.
- Scoreboard: reserve r10, then read r10 → rd_busy=1. Write r10 in the same cycle as a read of r10 → rd_busy=0 with the new data. Reserve and write r11 together, then read r11 → rd_busy=1.
- Hold and valid: a read with rd_en=1 followed by two cycles with rd_en=0 → rd_data unchanged and rd_valid sequence 1,0,0.
